// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, fixed access latency, word storage.
// Optional DMEM_BYTE_WRITE_EN: stores honour req_be; otherwise every good store writes all 32 bits.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  dbg_state
);
  // Handshake: a request transfers on a rising edge where req_valid && req_ready; a response
  // transfers on a rising edge where resp_valid && resp_ready. Neither side may retract or
  // change its payload while valid is high and ready is low.

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic          accept;
  logic          acc_err;
  logic          mem_we;
  logic [AW-1:0] idx;
  logic [31:0]   wmask;

  assign req_ready = (state_q == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign idx       = req_addr[AW+1:2];
  assign acc_err   = (req_addr[1:0] != 2'b00) ||
                     ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));
  assign mem_we    = accept && req_we && !acc_err;

`ifdef DMEM_BYTE_WRITE_EN
  assign wmask = {{8{req_be[3]}}, {8{req_be[2]}}, {8{req_be[1]}}, {8{req_be[0]}}};
`else
  logic unused_be;
  assign unused_be = ^req_be;
  assign wmask     = '1;
`endif

  // Storage has no reset so contents survive an abandoned transaction.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx] <= (mem[idx] & ~wmask) | (req_wdata & wmask);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          err_d   = acc_err;
          rdata_d = (!req_we && !acc_err) ? mem[idx] : 32'h0;
          cnt_d   = 4'(LATENCY - 1);
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
          rdata_d = 32'h0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed load/store vectors, expected responses queued
// at issue time and checked by an independent response monitor.
module tb_dmem_responder;
  localparam int DEPTH_WORDS = 256;
  localparam int LATENCY     = 2;
  localparam int BUDGET      = 60;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [3:0]  req_be = 4'h0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [1:0]  dbg_state;

  dmem_responder #(.DEPTH_WORDS(DEPTH_WORDS), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_be(req_be),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "global timeout");
  end

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          last_acc = 0;
  int          hs_cyc   = 0;
  logic        prev_valid = 1'b0;
  logic [31:0] held_rdata = 32'h0;
  logic        held_err   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge, judges what the next rising edge will see.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (resp_valid) begin
        if (!prev_valid) begin
          check("resp_expected", 64'(exp_q.size() != 0), 64'd1);
          check("latency", 64'(cyc + 1 - last_acc), 64'(LATENCY));
          held_rdata = resp_rdata;
          held_err   = resp_err;
        end else begin
          check("hold_rdata", 64'(resp_rdata), 64'(held_rdata));
          check("hold_err", 64'(resp_err), 64'(held_err));
        end
        check("req_ready_in_resp", 64'(req_ready), 64'd0);
        if (resp_ready) begin
          hs_cyc = cyc + 1;
          if (exp_q.size() != 0) begin
            check("resp_data_err", 64'({resp_err, resp_rdata}), 64'(exp_q.pop_front()));
          end
        end
      end
      prev_valid = resp_valid && !resp_ready;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input bit push, input logic [32:0] exp);
    int n;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < BUDGET) begin
      n++;
      @(negedge clk);
    end
    check("accept", 64'(req_ready), 64'd1);
    if (req_ready) begin
      last_acc = cyc + 1;
      if (push) exp_q.push_back(exp);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || resp_valid) && n < BUDGET) begin
      n++;
      @(negedge clk);
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] v20;

  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready", 64'(req_ready), 64'd0);
    check("reset_resp_valid", 64'(resp_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_req_ready", 64'(req_ready), 64'd1);
    check("idle_resp_valid", 64'(resp_valid), 64'd0);
    check("idle_resp_rdata", 64'(resp_rdata), 64'd0);
    check("idle_resp_err", 64'(resp_err), 64'd0);

    // store then load
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, {1'b0, 32'h0});
    issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, {1'b0, 32'hDEADBEEF});
    issue(1'b1, 32'h00, 32'h0BADF00D, 4'hF, 1'b1, {1'b0, 32'h0});

    // byte enables
    issue(1'b1, 32'h20, 32'h11223344, 4'hF, 1'b1, {1'b0, 32'h0});
    issue(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b1, {1'b0, 32'h0});
`ifdef DMEM_BYTE_WRITE_EN
    v20 = 32'h11BB33DD;
`else
    v20 = 32'hAABBCCDD;
`endif
    issue(1'b0, 32'h20, 32'h0, 4'h0, 1'b1, {1'b0, v20});
    issue(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 1'b1, {1'b0, 32'h0});
`ifndef DMEM_BYTE_WRITE_EN
    v20 = 32'hFFFFFFFF;
`endif
    issue(1'b0, 32'h20, 32'h0, 4'h0, 1'b1, {1'b0, v20});

    // errors, then confirm nothing was disturbed
    issue(1'b0, 32'h22, 32'h0, 4'h0, 1'b1, {1'b1, 32'h0});
    issue(1'b1, 32'h400, 32'h12345678, 4'hF, 1'b1, {1'b1, 32'h0});
    issue(1'b0, 32'h400, 32'h0, 4'h0, 1'b1, {1'b1, 32'h0});
    issue(1'b0, 32'h00, 32'h0, 4'h0, 1'b1, {1'b0, 32'h0BADF00D});
    issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, {1'b0, 32'hDEADBEEF});
    issue(1'b0, 32'h20, 32'h0, 4'h0, 1'b1, {1'b0, v20});

    // last legal word and a misaligned neighbour
    issue(1'b1, 32'h3FC, 32'hCAFE0001, 4'hF, 1'b1, {1'b0, 32'h0});
    issue(1'b0, 32'h3FC, 32'h0, 4'h0, 1'b1, {1'b0, 32'hCAFE0001});
    issue(1'b0, 32'h3FE, 32'h0, 4'h0, 1'b1, {1'b1, 32'h0});
    wait_idle();

    // backpressure: hold RESP for 5 cycles with a second request waiting
    resp_ready = 1'b0;
    issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, {1'b0, 32'hDEADBEEF});
    n = 0;
    @(negedge clk);
    while (!resp_valid && n < BUDGET) begin
      n++;
      @(negedge clk);
    end
    check("bp_resp_valid", 64'(resp_valid), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h20;
    repeat (5) begin
      @(negedge clk);
      check("bp_valid_held", 64'(resp_valid), 64'd1);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    issue(1'b0, 32'h20, 32'h0, 4'h0, 1'b1, {1'b0, v20});
    check("accept_after_hs", 64'(last_acc), 64'(hs_cyc + 1));
    wait_idle();

    // reset during WAIT abandons the load
    issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 33'h0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mid_req_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", 64'(req_ready), 64'd1);
    repeat (LATENCY + 2) begin
      @(negedge clk);
      check("no_resp_after_rst", 64'(resp_valid), 64'd0);
    end
    issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, {1'b0, 32'hDEADBEEF});
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
